// File: rtl/muldiv_pkg.sv
// Shared types for the execute-stage multiply/divide unit: operation codes,
// controller states and the default operand width.
package muldiv_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [2:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      DIV   = 3'd2,
      DIVU  = 3'd3,
      MADD  = 3'd4,
      MADDU = 3'd5,
      MSUB  = 3'd6,
      MSUBU = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } muldiv_state_e;

   // Unsigned variants all carry a 1 in bit 0 of the encoding.
   function automatic logic op_is_signed(muldiv_op_e op);
      return ~op[0];
   endfunction

   function automatic logic op_is_div(muldiv_op_e op);
      return (op == DIV) || (op == DIVU);
   endfunction

endpackage

// File: rtl/exe_muldiv_unit_if.sv
// Request/response bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface exe_muldiv_unit_if
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             start_i;
   muldiv_op_e       op_i;
   logic [WIDTH-1:0] opa_i;
   logic [WIDTH-1:0] opb_i;
   logic [WIDTH-1:0] hi_i;
   logic [WIDTH-1:0] lo_i;
   logic             annul_i;
   logic             busy_o;
   logic             ready_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;
   logic             div_zero_o;

   modport master (
      output start_i, op_i, opa_i, opb_i, hi_i, lo_i, annul_i,
      input  busy_o, ready_o, hi_o, lo_o, div_zero_o
   );

   modport slave (
      input  start_i, op_i, opa_i, opb_i, hi_i, lo_i, annul_i,
      output busy_o, ready_o, hi_o, lo_o, div_zero_o
   );

endinterface

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider: one setup cycle, WIDTH quotient-bit cycles,
// sign fix-up applied combinationally on the final iteration's result.
//
// state   | meaning
// C_IDLE  | waiting for i_start
// C_SETUP | take magnitudes, detect zero divisor
// C_ITER  | one restoring step per cycle, r_cnt down to 0
module muldiv_div_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_annul,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_opa,
   input  logic [WIDTH-1:0] i_opb,
   output logic             o_done,
   output logic             o_div_zero,
   output logic [WIDTH-1:0] o_quo,
   output logic [WIDTH-1:0] o_rem
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {C_IDLE, C_SETUP, C_ITER} core_state_e;

   core_state_e      r_st;
   logic [WIDTH-1:0] r_a, r_b, r_rem, r_quo, r_div;
   logic             r_signed, r_neg_q, r_neg_r;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH-1:0] w_abs_a, w_abs_b, w_rem_nx, w_quo_nx;
   logic [WIDTH:0]   w_sh, w_sub;
   logic             w_ge, w_zero;

   assign w_abs_a  = (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
   assign w_abs_b  = (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;
   assign w_zero   = (r_b == '0);
   assign w_sh     = {r_rem, r_quo[WIDTH-1]};
   assign w_ge     = (w_sh >= {1'b0, r_div});
   assign w_sub    = w_sh - {1'b0, r_div};
   assign w_rem_nx = w_ge ? w_sub[WIDTH-1:0] : w_sh[WIDTH-1:0];
   assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

   // Magnitude quotient of most-negative / -1 is already 2^(WIDTH-1) and the
   // signs match, so that case needs no special handling here.
   assign o_done     = ((r_st == C_SETUP) && w_zero) || ((r_st == C_ITER) && (r_cnt == '0));
   assign o_div_zero = (r_st == C_SETUP);
   assign o_quo      = (r_st == C_SETUP) ? '1  : (r_neg_q ? -w_quo_nx : w_quo_nx);
   assign o_rem      = (r_st == C_SETUP) ? r_a : (r_neg_r ? -w_rem_nx : w_rem_nx);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_st     <= C_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_signed <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_cnt    <= '0;
      end else if (i_annul) begin
         r_st <= C_IDLE;
      end else begin
         case (r_st)
            C_IDLE: begin
               if (i_start) begin
                  r_a      <= i_opa;
                  r_b      <= i_opb;
                  r_signed <= i_signed;
                  r_st     <= C_SETUP;
               end
            end
            C_SETUP: begin
               if (w_zero) begin
                  r_st <= C_IDLE;
               end else begin
                  r_rem   <= '0;
                  r_quo   <= w_abs_a;
                  r_div   <= w_abs_b;
                  r_neg_q <= r_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                  r_neg_r <= r_signed && r_a[WIDTH-1];
                  r_cnt   <= CW'(WIDTH - 1);
                  r_st    <= C_ITER;
               end
            end
            C_ITER: begin
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx;
               if (r_cnt == '0) r_st <= C_IDLE;
               else             r_cnt <= r_cnt - CW'(1);
            end
            default: r_st <= C_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/exe_muldiv_unit.sv
// Multi-cycle multiply/divide unit producing {hi, lo} for the HI/LO path.
// Define MULDIV_ACCUM_EN to enable MADD/MSUB accumulation into {hi_i, lo_i}.
//
// state   | meaning
// ST_IDLE | no operation, accepts start_i
// ST_MUL  | product moving through the multiply pipeline
// ST_DIV  | divider core running
// ST_DONE | ready_o high for one cycle, accepts start_i
module exe_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int MUL_STAGES = 2
) (
   input logic              clk,
   input logic              rst,
   exe_muldiv_unit_if.slave bus
);

   localparam int DW     = 2 * WIDTH;
   localparam int PIPE_N = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
   localparam int CW     = $clog2(MUL_STAGES + 1);

   muldiv_state_e    r_state;
   muldiv_op_e       r_op;
   logic [WIDTH-1:0] r_opa, r_opb, r_hi, r_lo;
   logic             r_dz, r_ready;
   logic [CW-1:0]    r_cnt;
   logic [DW-1:0]    r_pipe [PIPE_N];

   muldiv_op_e       w_op_dec;
   logic             w_accept, w_div_done, w_div_zero;
   logic [WIDTH-1:0] w_quo, w_rem;
   logic [DW-1:0]    w_ext_a, w_ext_b, w_prod, w_tap, w_mul_res;

   function automatic muldiv_op_e op_decode(muldiv_op_e op);
`ifdef MULDIV_ACCUM_EN
      return op;
`else
      case (op)
         MADD, MSUB:   return MULT;
         MADDU, MSUBU: return MULTU;
         default:      return op;
      endcase
`endif
   endfunction

   assign w_op_dec = op_decode(bus.op_i);
   assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && bus.start_i && !bus.annul_i;

   muldiv_div_core #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_accept && op_is_div(w_op_dec)),
      .i_annul   (bus.annul_i),
      .i_signed  (op_is_signed(w_op_dec)),
      .i_opa     (bus.opa_i),
      .i_opb     (bus.opb_i),
      .o_done    (w_div_done),
      .o_div_zero(w_div_zero),
      .o_quo     (w_quo),
      .o_rem     (w_rem)
   );

   assign w_ext_a = op_is_signed(r_op) ? {{WIDTH{r_opa[WIDTH-1]}}, r_opa} : {{WIDTH{1'b0}}, r_opa};
   assign w_ext_b = op_is_signed(r_op) ? {{WIDTH{r_opb[WIDTH-1]}}, r_opb} : {{WIDTH{1'b0}}, r_opb};
   assign w_prod  = w_ext_a * w_ext_b;

   always_ff @(posedge clk) begin
      r_pipe[0] <= w_prod;
      for (int i = 1; i < PIPE_N; i++) r_pipe[i] <= r_pipe[i-1];
   end

   // The output register is the last multiply stage, so the tap sits one short.
   generate
      if (MUL_STAGES > 1) begin : g_tap_pipe
         assign w_tap = r_pipe[PIPE_N-1];
      end else begin : g_tap_direct
         assign w_tap = w_prod;
      end
   endgenerate

`ifdef MULDIV_ACCUM_EN
   logic [DW-1:0] r_acc;

   always_comb begin
      w_mul_res = w_tap;
      case (r_op)
         MADD, MADDU: w_mul_res = r_acc + w_tap;
         MSUB, MSUBU: w_mul_res = r_acc - w_tap;
         default:     w_mul_res = w_tap;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst)          r_acc <= '0;
      else if (w_accept) r_acc <= {bus.hi_i, bus.lo_i};
   end
`else
   assign w_mul_res = w_tap;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_op    <= MULT;
         r_opa   <= '0;
         r_opb   <= '0;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_dz    <= 1'b0;
         r_ready <= 1'b0;
      end else if (bus.annul_i) begin
         r_state <= ST_IDLE;
         r_ready <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (bus.start_i) begin
                  r_op    <= w_op_dec;
                  r_opa   <= bus.opa_i;
                  r_opb   <= bus.opb_i;
                  r_cnt   <= CW'(MUL_STAGES - 1);
                  r_state <= op_is_div(w_op_dec) ? ST_DIV : ST_MUL;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_MUL: begin
               if (r_cnt == '0) begin
                  {r_hi, r_lo} <= w_mul_res;
                  r_dz         <= 1'b0;
                  r_ready      <= 1'b1;
                  r_state      <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            ST_DIV: begin
               if (w_div_done) begin
                  r_hi    <= w_rem;
                  r_lo    <= w_quo;
                  r_dz    <= w_div_zero;
                  r_ready <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy_o     = (r_state == ST_MUL) || (r_state == ST_DIV);
   assign bus.ready_o    = r_ready;
   assign bus.hi_o       = r_hi;
   assign bus.lo_o       = r_lo;
   assign bus.div_zero_o = r_dz;

endmodule

// File: doc/exe_muldiv_unit.md
# exe_muldiv_unit

Parametrised multi-cycle multiply/divide unit for the execute stage. It replaces the fixed 32-clock divider and the ALU-internal multiply stall with one block that has a start/ready handshake, a configurable operand width and multiply pipeline depth, and mid-operation annul on flush. It produces the {hi, lo} pair consumed by the EX→MEM HI/LO path.

## Interface
Parameters:
- WIDTH, 32, operand width; hi_o and lo_o are each WIDTH bits.
- MUL_STAGES, 2, number of multiply pipeline register stages (≥1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- start_i  in  1  request a new operation; sampled only when the unit can accept.
- op_i  in  3  operation code, a muldiv_op_e value: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
- opa_i  in  WIDTH  rs operand: multiplicand or dividend.
- opb_i  in  WIDTH  rt operand: multiplier or divisor.
- hi_i, lo_i  in  WIDTH each  current HI/LO (already forwarded); accumulate source.
- annul_i  in  1  flush; aborts any in-flight operation.
- busy_o  out  1  an operation is in flight.
- ready_o  out  1  one-cycle pulse; hi_o/lo_o/div_zero_o are valid.
- hi_o, lo_o  out  WIDTH each  result. Divide: hi = remainder, lo = quotient. Multiply: the 2·WIDTH product or accumulation.
- div_zero_o  out  1  last divide had a zero divisor.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- start_i is accepted in IDLE or DONE; this allows back-to-back operations. start_i is ignored in MUL and DIV.
- Operands and op are latched on the accepting edge; inputs may change afterwards.
- MUL: the product travels through MUL_STAGES registers, then the state goes to DONE.
  - Signed ops sign-extend to 2·WIDTH; unsigned ops zero-extend.
- DIV, one setup cycle:
  - Form |opa| and |opb| for signed ops.
  - A zero divisor goes straight to DONE with hi=opa, lo=all-ones, div_zero_o=1.
- DIV, iteration: WIDTH restoring iterations, one quotient bit per cycle.
- DIV, fix-up cycle:
  - The quotient is negated if the operand signs differ (signed ops only).
  - The remainder takes the sign of the dividend.
  - Most-negative ÷ −1 gives lo=0x8000_0000 (for WIDTH=32) and hi=0, with no flag.
- DONE lasts one cycle and asserts ready_o. The next state is IDLE, or a new op if start_i is high.
- Results and div_zero_o hold from DONE until the next ready_o. div_zero_o is cleared by a non-divide or a nonzero-divisor completion.
- annul_i: the next edge forces IDLE from any state. There is no ready_o, and result registers are unchanged.
  - If annul_i and start_i are high together, annul wins and the start is dropped.
- Reset: state IDLE; busy_o, ready_o, hi_o, lo_o and div_zero_o are all 0. Reset applies mid-operation identically.

## Timing
- Counting the accepting edge as cycle 0:
  - Multiply ready_o is high in cycle MUL_STAGES+1; the default is 3.
  - Divide ready_o is high in cycle WIDTH+2; the default is 34.
  - Zero-divisor ready_o is high in cycle 2.
- busy_o is high from cycle 1 up to, but not including, the ready_o cycle.
  - busy_o is combinational from the state.
  - The pipeline stall is driven as start_i | busy_o by the instantiating stage.
- Back-to-back: a start accepted in the DONE cycle gives the next ready_o with the same latency from that edge.

## Configuration
- MULDIV_ACCUM_EN defined:
  - MADD/MADDU: {hi,lo} = {hi_i,lo_i} + product.
  - MSUB/MSUBU: {hi,lo} = {hi_i,lo_i} − product.
  - hi_i/lo_i are latched at start, and the add/sub is performed in the final MUL stage. Latency is unchanged.
- MULDIV_ACCUM_EN undefined:
  - MADD/MSUB decode as MULT, and MADDU/MSUBU as MULTU.
  - hi_i and lo_i remain ports but are unused.

## Structure
- Package muldiv_pkg holds:
  - the muldiv_op_e enum (3-bit encoding);
  - the muldiv_state_e enum;
  - a DEFAULT_WIDTH constant.
- Sub-module muldiv_div_core contains the iterative restoring divider (abs/setup, iteration counter, fix-up) with its own start/done pair.
- The top level holds the FSM, the multiply pipeline, accumulate logic and output registers.

## Test plan
- MULT, opa=0xFFFF_FFFF, opb=2 → hi=0xFFFF_FFFF, lo=0xFFFF_FFFE, ready_o in cycle 3 and busy_o high in cycles 1–2.
- DIVU 100/7 → hi=2, lo=14, ready_o in cycle 34. DIV −7/2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0, div_zero_o=0.
- DIVU 5/0 → ready_o in cycle 2 with hi=5, lo=0xFFFF_FFFF, div_zero_o=1. A following MULTU 3×4 → lo=12 and div_zero_o=0.
- DIV started, annul_i in cycle 10 → no ready_o, busy_o=0 in cycle 11, and prior results held.
  - annul_i together with start_i → start dropped.
  - rst low in cycle 5 → all outputs 0.
- With MULDIV_ACCUM_EN: MADDU, hi_i=0, lo_i=10, 3×4 → lo=22. MSUB, hi_i=0, lo_i=0, 1×1 → {hi,lo}=all-ones.
- Without MULDIV_ACCUM_EN: the same MADDU → lo=12.
